s2mm_cmd_sequencer: RTL and testbench

- Queues transfer descriptors (destination address, byte length) and runs them one at a time through the S2MM stream-to-memory engine, using that engine's AXI4-Lite register file.
- Acts as an AXI4-Lite master: programs ADDR (0x10), LEN (0x14) and CTRL start (0x00 = 1), then polls STATUS (0x04) until done.
- Sits between a local command source (CPU-side glue or test sequencer) and the S2MM engine's control port, so software no longer hand-drives each transfer.

---
 rtl/s2mm_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_s2mm_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_cmd_sequencer.sv
// s2mm_cmd_sequencer: queues (addr, len) descriptors and runs each through the S2MM engine
// over AXI4-Lite: writes ADDR, LEN and CTRL start, then polls STATUS until done.
module s2mm_cmd_sequencer #(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          POLL_GAP   = 4,
   parameter int          POLL_LIMIT = 0
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] desc_addr,
   input  logic [31:0] desc_len,
   input  logic        desc_valid,
   output logic        desc_ready,
   input  logic        err_clear,
   output logic [31:0] m_awaddr,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [31:0] m_araddr,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic        busy,
   output logic        done_pulse,
   output logic [15:0] done_count,
   output logic        err,
   output logic [1:0]  err_code
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [3:0] {IDLE, WR_ADDR, WR_LEN, WR_CTRL, POLL_AR, POLL_R, POLL_WAIT, DONE, ERR} state_t;
   state_t      state;
   logic [31:0] addr_mem [FIFO_DEPTH];
   logic [31:0] len_mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt, cnt_nxt;
   logic        push, pop, issued, aw_ok, w_ok, status_done;
   logic [31:0] h_addr, h_len, poll_cnt, gap_cnt, wr_off, wr_val;
   assign push        = desc_valid && desc_ready;
   assign pop         = state == IDLE && cnt != '0 && !err;
   assign cnt_nxt     = cnt + (AW+1)'(push) - (AW+1)'(pop);
   assign m_araddr    = BASE_ADDR + 32'h4;
   assign m_wstrb     = 4'hF;
   assign wr_off      = state == WR_ADDR ? 32'h10 : state == WR_LEN ? 32'h14 : 32'h0;
   assign wr_val      = state == WR_ADDR ? h_addr : state == WR_LEN ? h_len : 32'h1;
   assign aw_ok       = !m_awvalid || m_awready;
   assign w_ok        = !m_wvalid || m_wready;
   assign status_done = (m_rdata & 32'h1) != 32'h0;
   // desc_ready is registered from the next count, so it never depends on desc_valid
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wp         <= '0;
         rp         <= '0;
         cnt        <= '0;
         desc_ready <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt        <= cnt_nxt;
         desc_ready <= cnt_nxt != (AW+1)'(FIFO_DEPTH);
      end
   end
   always_ff @(posedge aclk) begin
      if (push) begin
         addr_mem[wp] <= desc_addr;
         len_mem[wp]  <= desc_len;
      end
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         h_addr     <= '0;
         h_len      <= '0;
         poll_cnt   <= '0;
         gap_cnt    <= '0;
         issued     <= 1'b0;
         m_awaddr   <= '0;
         m_awvalid  <= 1'b0;
         m_wdata    <= '0;
         m_wvalid   <= 1'b0;
         m_bready   <= 1'b0;
         m_arvalid  <= 1'b0;
         m_rready   <= 1'b0;
         busy       <= 1'b0;
         done_pulse <= 1'b0;
         done_count <= '0;
         err        <= 1'b0;
         err_code   <= 2'b00;
      end else begin
         done_pulse <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               h_addr   <= addr_mem[rp];
               h_len    <= len_mem[rp];
               poll_cnt <= '0;
               if (len_mem[rp] == '0) begin
                  state      <= DONE;
                  done_pulse <= 1'b1;
                  done_count <= done_count + 16'd1;
               end else begin
                  state <= WR_ADDR;
                  busy  <= 1'b1;
               end
            end
            // each register write: issue, wait both handshakes, then collect the response
            WR_ADDR, WR_LEN, WR_CTRL:
               if (!issued) begin
                  issued    <= 1'b1;
                  m_awvalid <= 1'b1;
                  m_wvalid  <= 1'b1;
                  m_awaddr  <= BASE_ADDR + wr_off;
                  m_wdata   <= wr_val;
               end else if (!m_bready) begin
                  if (m_awready) m_awvalid <= 1'b0;
                  if (m_wready) m_wvalid <= 1'b0;
                  if (aw_ok && w_ok) m_bready <= 1'b1;
               end else if (m_bvalid) begin
                  m_bready <= 1'b0;
                  issued   <= 1'b0;
                  if (m_bresp != 2'b00) begin
                     state    <= ERR;
                     err      <= 1'b1;
                     err_code <= 2'b01;
                     busy     <= 1'b0;
                  end else if (state == WR_CTRL) begin
                     state     <= POLL_AR;
                     m_arvalid <= 1'b1;
                  end else state <= state == WR_ADDR ? WR_LEN : WR_CTRL;
               end
            POLL_AR: if (m_arready) begin
               m_arvalid <= 1'b0;
               m_rready  <= 1'b1;
               state     <= POLL_R;
            end
            POLL_R: if (m_rvalid) begin
               m_rready <= 1'b0;
               if (m_rresp != 2'b00) begin
                  state    <= ERR;
                  err      <= 1'b1;
                  err_code <= 2'b10;
                  busy     <= 1'b0;
               end else if (status_done) begin
                  state      <= DONE;
                  done_pulse <= 1'b1;
                  done_count <= done_count + 16'd1;
                  busy       <= 1'b0;
               end else begin
                  poll_cnt <= poll_cnt + 32'd1;
                  gap_cnt  <= '0;
                  if (POLL_LIMIT != 0 && poll_cnt + 32'd1 == 32'(POLL_LIMIT)) begin
                     state    <= ERR;
                     err      <= 1'b1;
                     err_code <= 2'b11;
                     busy     <= 1'b0;
                  end else if (POLL_GAP == 0) begin
                     state     <= POLL_AR;
                     m_arvalid <= 1'b1;
                  end else state <= POLL_WAIT;
               end
            end
            POLL_WAIT:
               if (gap_cnt == 32'(POLL_GAP - 1)) begin
                  state     <= POLL_AR;
                  m_arvalid <= 1'b1;
               end else gap_cnt <= gap_cnt + 32'd1;
            DONE: state <= IDLE;
            ERR: if (err_clear) begin
               err      <= 1'b0;
               err_code <= 2'b00;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_s2mm_cmd_sequencer.sv
// tb_s2mm_cmd_sequencer: directed bench with a behavioural AXI4-Lite slave standing in for the S2MM engine.
module tb_s2mm_cmd_sequencer;
   logic        aclk = 0, aresetn = 0;
   logic [31:0] desc_addr = 0, desc_len = 0;
   logic        desc_valid = 0, err_clear = 0;
   logic        desc_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
   logic        busy, done_pulse, err;
   logic [31:0] m_awaddr, m_wdata, m_araddr;
   logic [3:0]  m_wstrb;
   logic [15:0] done_count;
   logic [1:0]  err_code;
   logic        m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
   logic [1:0]  m_bresp = 0, m_rresp = 0;
   logic [31:0] m_rdata = 0;
   int          total = 0, bad = 0;
   int          cyc = 0, wr_n = 0, rd_n = 0, dp_n = 0, viol = 0;
   int          fail_wr = -1, aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
   int          busy_rise = 0, dp_last = 0, r0 = 0, w0 = 0;
   logic [31:0] wa_q[$], wd_q[$], st_q[$];
   int          ar_cyc[$];
   bit          aw_got, w_got, p_aw, p_w, p_b, p_ar, p_r, prev_awv, prev_wv, prev_busy;
   logic [31:0] aw_cap, w_cap, pa, pd, prev_awa, prev_wd;

   s2mm_cmd_sequencer #(.POLL_LIMIT(3)) dut (
      .aclk(aclk), .aresetn(aresetn), .desc_addr(desc_addr), .desc_len(desc_len),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .err_clear(err_clear),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .busy(busy), .done_pulse(done_pulse), .done_count(done_count), .err(err), .err_code(err_code)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   // slave works on falling edges: first retire handshakes of the last rising edge, then set up the next
   always @(negedge aclk) begin
      if (!aresetn) begin
         m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_arready = 0;
         m_rvalid = 0; m_rresp = 0; m_rdata = 0;
         aw_got = 0; w_got = 0; p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
         aw_cnt = 0; w_cnt = 0; prev_awv = 0; prev_wv = 0; prev_busy = 0;
      end else begin
         if (prev_awv && !p_aw && (!m_awvalid || m_awaddr != prev_awa)) viol++;
         if (prev_wv && !p_w && (!m_wvalid || m_wdata != prev_wd)) viol++;
         if (p_aw) begin aw_got = 1; aw_cap = pa; end
         if (p_w) begin w_got = 1; w_cap = pd; end
         if (p_b) m_bvalid = 0;
         if (p_r) m_rvalid = 0;
         if (p_ar) begin
            m_rvalid = 1;
            m_rresp = 0;
            m_rdata = st_q.size() > 0 ? st_q.pop_front() : 32'h1;
            rd_n++;
            ar_cyc.push_back(cyc);
         end
         if (aw_got && w_got) begin
            wa_q.push_back(aw_cap);
            wd_q.push_back(w_cap);
            m_bresp = (wr_n == fail_wr) ? 2'b10 : 2'b00;
            wr_n++;
            m_bvalid = 1;
            aw_got = 0;
            w_got = 0;
         end
         if (m_bready && !m_bvalid) viol++;
         m_awready = m_awvalid && aw_cnt >= aw_dly;
         aw_cnt = m_awvalid ? aw_cnt + 1 : 0;
         m_wready = m_wvalid && w_cnt >= w_dly;
         w_cnt = m_wvalid ? w_cnt + 1 : 0;
         m_arready = 1;
         if (done_pulse) begin dp_n++; dp_last = cyc; end
         if (busy && !prev_busy) busy_rise = cyc;
         prev_busy = busy;
         p_aw = m_awvalid && m_awready; pa = m_awaddr;
         p_w = m_wvalid && m_wready; pd = m_wdata;
         p_b = m_bvalid && m_bready;
         p_ar = m_arvalid && m_arready;
         p_r = m_rvalid && m_rready;
         prev_awv = m_awvalid; prev_awa = m_awaddr;
         prev_wv = m_wvalid; prev_wd = m_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge aclk);
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] l);
      int g = 0;
      while (!desc_ready && g < 300) begin @(negedge aclk); g++; end
      chk("push_ready", desc_ready, 1);
      desc_valid = 1; desc_addr = a; desc_len = l;
      @(negedge aclk);
      desc_valid = 0;
   endtask

   task automatic wait_dp(input int tgt, input int lim);
      int g = 0;
      while (dp_n < tgt && g < lim) begin @(negedge aclk); g++; end
   endtask

   task automatic wait_err(input int lim);
      int g = 0;
      while (!err && g < lim) begin @(negedge aclk); g++; end
   endtask

   task automatic clear_err;
      err_clear = 1;
      @(negedge aclk);
      err_clear = 0;
   endtask

   initial begin
      tick(3);
      chk("rst_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, done_pulse}, 0);
      chk("rst_ready", desc_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", done_count, 0);
      chk("rst_err", {err, err_code}, 0);
      aresetn = 1;
      tick(2);
      chk("ready_up", desc_ready, 1);
      // basic descriptor, STATUS 0,0,1
      st_q = '{32'h0, 32'h0};
      push(32'hC000_0007, 6);
      wait_dp(1, 400);
      chk("t1_done", dp_n, 1);
      chk("t1_count", done_count, 1);
      chk("t1_wr_n", wr_n, 3);
      chk("t1_a0", wa_q[0], 32'h4000_0010);
      chk("t1_d0", wd_q[0], 32'hC000_0007);
      chk("t1_a1", wa_q[1], 32'h4000_0014);
      chk("t1_d1", wd_q[1], 6);
      chk("t1_a2", wa_q[2], 32'h4000_0000);
      chk("t1_d2", wd_q[2], 1);
      chk("t1_wstrb", m_wstrb, 4'hF);
      chk("t1_rd_n", rd_n, 3);
      chk("t1_gap1", ar_cyc[1] - ar_cyc[0], 6);
      chk("t1_gap2", ar_cyc[2] - ar_cyc[1], 6);
      chk("t1_busy", busy, 0);
      // awready late, then wready late
      aw_dly = 3;
      push(32'h1234_5679, 32'h100);
      wait_dp(2, 400);
      chk("t3_a0", wa_q[3], 32'h4000_0010);
      chk("t3_d0", wd_q[3], 32'h1234_5679);
      chk("t3_a1", wa_q[4], 32'h4000_0014);
      chk("t3_d1", wd_q[4], 32'h100);
      chk("t3_d2", wd_q[5], 1);
      aw_dly = 0; w_dly = 3;
      push(32'h8000_0002, 32'h40);
      wait_dp(3, 400);
      chk("t3b_d0", wd_q[6], 32'h8000_0002);
      chk("t3b_d1", wd_q[7], 32'h40);
      chk("t3b_a2", wa_q[8], 32'h4000_0000);
      chk("t3_viol", viol, 0);
      w_dly = 0;
      // bresp error on the LEN write, then a full queue while halted
      fail_wr = 10;
      push(32'hA000_0000, 8);
      wait_err(300);
      tick(5);
      chk("t4_err", err, 1);
      chk("t4_code", err_code, 2'b01);
      chk("t4_wr_n", wr_n, 11);
      chk("t4_len", wd_q[10], 8);
      chk("t4_busy", busy, 0);
      fail_wr = -1;
      for (int i = 1; i <= 4; i++) begin
         push(32'h100 * i, 4);
         if (i == 3) chk("t2_ready3", desc_ready, 1);
      end
      chk("t2_full", desc_ready, 0);
      clear_err;
      chk("t4_clr", {err, err_code}, 0);
      push(32'h500, 4);
      wait_dp(8, 2000);
      chk("t2_dp", dp_n, 8);
      chk("t2_count", done_count, 8);
      for (int i = 0; i < 5; i++) chk("t2_order", wd_q[11 + 3 * i], 32'h100 * (i + 1));
      chk("t2_latency", dp_last - busy_rise, 11);
      chk("t2_viol", viol, 0);
      // poll timeout, then a zero-length descriptor
      st_q = '{32'h0, 32'h0, 32'h0};
      r0 = rd_n;
      push(32'h7000_0000, 16);
      wait_err(400);
      chk("t5_code", err_code, 2'b11);
      chk("t5_reads", rd_n - r0, 3);
      clear_err;
      w0 = wr_n; r0 = rd_n;
      push(32'h9000_0000, 0);
      wait_dp(9, 100);
      chk("t5_zero_dp", dp_n, 9);
      chk("t5_zero_wr", wr_n - w0, 0);
      chk("t5_zero_rd", rd_n - r0, 0);
      chk("t5_count", done_count, 9);
      // reset while polling with two descriptors queued
      st_q.delete();
      push(32'h1000, 4);
      push(32'h2000, 4);
      push(32'h3000, 4);
      begin
         int g = 0;
         while (!m_rready && g < 200) begin @(negedge aclk); g++; end
      end
      chk("t6_in_poll", m_rready, 1);
      #1 aresetn = 0;
      @(negedge aclk);
      chk("t6_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, done_pulse}, 0);
      chk("t6_ready", desc_ready, 0);
      chk("t6_busy", busy, 0);
      chk("t6_count", done_count, 0);
      chk("t6_err", {err, err_code}, 0);
      aresetn = 1;
      w0 = wr_n;
      tick(30);
      chk("t6_flushed", wr_n - w0, 0);
      chk("t6_idle", busy, 0);
      chk("t6_ready_up", desc_ready, 1);
      chk("t6_count2", done_count, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
